// File: rtl/wb_regfile.sv
// Y86-64 SEQ write-back stage and architectural register file: decodes dstE/dstM,
// commits valE/valM on the clock edge, and serves two bypassable decode read ports.
module wb_regfile #(
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       NREGS      = 15,
    parameter int unsigned       RSP_IDX    = 4,
    parameter logic [DATA_W-1:0] STACK_INIT = '0,
    parameter bit                BYPASS     = 1'b1,
    parameter int unsigned       CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] rdataA,
    output logic [DATA_W-1:0] rdataB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [3:0] {
        I_HALT  = 4'h0,
        I_NOP   = 4'h1,
        I_RRMOV = 4'h2,
        I_IRMOV = 4'h3,
        I_RMMOV = 4'h4,
        I_MRMOV = 4'h5,
        I_OPQ   = 4'h6,
        I_JXX   = 4'h7,
        I_CALL  = 4'h8,
        I_RET   = 4'h9,
        I_PUSH  = 4'hA,
        I_POP   = 4'hB
    } icode_e;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'(RSP_IDX);

    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              commit;
    logic              we_e, we_m;
    logic [DATA_W-1:0] regs_rd [NREGS];

    function automatic logic idx_ok(input logic [3:0] idx);
        return (32'(idx) < NREGS) && (idx != RNONE);
    endfunction

    always_comb begin
        dstE = RNONE;
        dstM = RNONE;
        case (icode_e'(icode))
            I_RRMOV: dstE = cnd ? rB : RNONE;
            I_IRMOV,
            I_OPQ:   dstE = rB;
            I_CALL,
            I_RET,
            I_PUSH:  dstE = RSP;
            I_POP: begin
                dstE = RSP;
                dstM = rA;
            end
            I_MRMOV: dstM = rA;
            default: ;
        endcase
    end

    assign commit = valid & ~halted_q;
    assign we_e   = commit & idx_ok(dstE);
    assign we_m   = commit & idx_ok(dstM);

    // One storage element per register; the M port is checked first so it wins a dstE==dstM collision.
    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        logic [DATA_W-1:0] reg_q, reg_d;

        always_comb begin
            reg_d = reg_q;
            if (we_m && dstM == 4'(g)) begin
                reg_d = valM;
            end else if (we_e && dstE == 4'(g)) begin
                reg_d = valE;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                reg_q <= (g == RSP_IDX) ? STACK_INIT : '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign regs_rd[g] = reg_q;
    end

    always_comb begin
        halted_d  = halted_q;
        retired_d = retired_q;
        if (commit) begin
            retired_d = retired_q + CNT_W'(1);
            if (icode == I_HALT) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [3:0]        src,
        input logic              we_e_f,
        input logic              we_m_f,
        input logic [3:0]        dst_e,
        input logic [3:0]        dst_m,
        input logic [DATA_W-1:0] val_e,
        input logic [DATA_W-1:0] val_m,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] r;
        r = '0;
        if (idx_ok(src)) begin
            if (BYPASS && we_m_f && src == dst_m) begin
                r = val_m;
            end else if (BYPASS && we_e_f && src == dst_e) begin
                r = val_e;
            end else begin
                r = stored;
            end
        end
        return r;
    endfunction

    always_comb begin
        rdataA = '0;
        rdataB = '0;
        if (idx_ok(srcA)) begin
            rdataA = read_port(srcA, we_e, we_m, dstE, dstM, valE, valM, regs_rd[srcA]);
        end
        if (idx_ok(srcB)) begin
            rdataB = read_port(srcB, we_e, we_m, dstE, dstM, valE, valM, regs_rd[srcB]);
        end
    end

    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: one bypassing DUT (4-bit counter, STACK_INIT=0x100) and one
// non-bypassing DUT share stimulus; both are checked against an array-level model.
module tb_wb_regfile;

    typedef logic [63:0] regs_t [15];

    logic        clk = 1'b0;
    logic        rst, valid, cnd;
    logic [3:0]  icode, rA, rB, srcA, srcB;
    logic [63:0] valE, valM;

    logic [63:0] rdataA1, rdataB1, rdataA2, rdataB2;
    logic [3:0]  dstE1, dstM1, dstE2, dstM2;
    logic        halted1, halted2;
    logic [3:0]  retired1;
    logic [31:0] retired2;

    int checks   = 0;
    int failures = 0;

    regs_t       m1, m2;
    logic        m_halt;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    wb_regfile #(
        .DATA_W(64), .NREGS(15), .RSP_IDX(4), .STACK_INIT(64'h100), .BYPASS(1'b1), .CNT_W(4)
    ) u_dut (
        .clk(clk), .rst(rst), .valid(valid), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
        .rdataA(rdataA1), .rdataB(rdataB1), .dstE(dstE1), .dstM(dstM1),
        .halted(halted1), .retired(retired1)
    );

    wb_regfile #(
        .DATA_W(64), .NREGS(15), .RSP_IDX(4), .STACK_INIT(64'h0), .BYPASS(1'b0), .CNT_W(32)
    ) u_nb (
        .clk(clk), .rst(rst), .valid(valid), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
        .rdataA(rdataA2), .rdataB(rdataB2), .dstE(dstE2), .dstM(dstM2),
        .halted(halted2), .retired(retired2)
    );

    function automatic logic [3:0] exp_dstE(input logic [3:0] ic, input logic [3:0] rb, input logic c);
        case (ic)
            4'h2:                   return c ? rb : 4'hF;
            4'h3, 4'h6:             return rb;
            4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] exp_dstM(input logic [3:0] ic, input logic [3:0] ra);
        return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
    endfunction

    // Register contents as they will stand after this cycle's edge (ignoring rst).
    function automatic regs_t after_commit(input regs_t r);
        regs_t t;
        logic [3:0] de, dm;
        t = r;
        if (valid && !m_halt) begin
            de = exp_dstE(icode, rB, cnd);
            dm = exp_dstM(icode, rA);
            if (de != 4'hF) t[de] = valE;
            if (dm != 4'hF) t[dm] = valM;
        end
        return t;
    endfunction

    function automatic logic [63:0] rd(input regs_t r, input logic [3:0] s);
        return (s == 4'hF) ? 64'h0 : r[s];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) begin
            m1[i] = 64'h0;
            m2[i] = 64'h0;
        end
        m1[4]  = 64'h100;
        m_halt = 1'b0;
        m_ret  = 32'h0;
    endtask

    // Apply inputs just after an edge, check combinational and stored outputs
    // mid-cycle, then advance the model across the next edge.
    task automatic step(input logic r, input logic v, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input logic c, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [3:0] sa, input logic [3:0] sb);
        regs_t n1;
        rst = r; valid = v; icode = ic; rA = ra; rB = rb; cnd = c;
        valE = ve; valM = vm; srcA = sa; srcB = sb;
        #3;
        n1 = after_commit(m1);
        check("dstE",  64'(dstE1), 64'(exp_dstE(ic, rb, c)));
        check("dstM",  64'(dstM1), 64'(exp_dstM(ic, ra)));
        check("dstE_nb", 64'(dstE2), 64'(exp_dstE(ic, rb, c)));
        check("halted",  64'(halted1), 64'(m_halt));
        check("halted_nb", 64'(halted2), 64'(m_halt));
        check("retired", 64'(retired1), 64'(m_ret[3:0]));
        check("retired_nb", 64'(retired2), 64'(m_ret));
        if (!r) begin
            check("rdataA_byp", rdataA1, rd(n1, sa));
            check("rdataB_byp", rdataB1, rd(n1, sb));
            check("rdataA_nb",  rdataA2, rd(m2, sa));
            check("rdataB_nb",  rdataB2, rd(m2, sb));
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            m1 = n1;
            m2 = after_commit(m2);
            if (v && !m_halt) begin
                if (ic == 4'h0) m_halt = 1'b1;
                m_ret = m_ret + 32'h1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        valE = '0; valM = '0; srcA = 4'hF; srcB = 4'hF;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h0, 4'h0);

        // Reset contents across every index
        for (int s = 0; s < 16; s += 2)
            step(0, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'(s), 4'(s + 1));

        // irmovq then OPq, bypass visible in the commit cycle
        step(0, 1, 4'h3, 4'hF, 4'h6, 0, 64'd140, 0, 4'h6, 4'h2);
        step(0, 1, 4'h6, 4'hF, 4'h2, 0, 64'd10,  0, 4'h6, 4'h2);
        step(0, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h6, 4'h2);

        // cmovXX not taken / taken
        step(0, 1, 4'h2, 4'hF, 4'h3, 0, 64'd9, 0, 4'h3, 4'h3);
        step(0, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h3, 4'h4);
        step(0, 1, 4'h2, 4'hF, 4'h3, 1, 64'd9, 0, 4'h3, 4'h3);
        step(0, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h3, 4'h4);

        // popq %rsp collision, then popq %rdx
        step(0, 1, 4'hB, 4'h4, 4'hF, 0, 64'd40, 64'd5, 4'h4, 4'h2);
        step(0, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h4, 4'h2);
        step(0, 1, 4'hB, 4'h2, 4'hF, 0, 64'd12, 64'd7, 4'h4, 4'h2);
        step(0, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h4, 4'h2);

        // Destination F is dropped
        step(0, 1, 4'h3, 4'hF, 4'hF, 0, 64'hDEAD, 0, 4'hF, 4'h0);
        step(0, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'hF, 4'h0);

        // rst and commit on the same edge
        step(1, 1, 4'h3, 4'hF, 4'h5, 0, 64'd99, 0, 4'h5, 4'h4);
        step(0, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h5, 4'h4);

        // Halt, suppressed commit afterwards, then rst clears it
        step(0, 1, 4'h0, 4'hF, 4'hF, 0, 0, 0, 4'h1, 4'h4);
        step(0, 1, 4'h3, 4'hF, 4'h1, 0, 64'd77, 0, 4'h1, 4'h4);
        step(0, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h1, 4'h4);
        step(1, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h1, 4'h4);
        step(0, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h1, 4'h4);

        // 16 commits wrap the 4-bit counter back to its start
        for (int i = 0; i < 16; i++)
            step(0, 1, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h0, 4'h4);
        step(0, 0, 4'h1, 4'hF, 4'hF, 0, 0, 0, 4'h0, 4'h4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 49) == 0) || (m_halt && $urandom_range(0, 5) == 0);
            step(r, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 11)),
                 4'($urandom), 4'($urandom), 1'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 4'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Parametrised write-back stage plus architectural register file for the Y86-64 SEQ core. It decodes the write destinations dstE and dstM from icode, rA, rB and the condition flag, then commits valE/valM into the register file on the clock edge. It also provides two read ports for the decode stage, with optional same-cycle write bypass, a halt latch and a retired-instruction counter. It sits between the memory stage and the decode stage, replacing the fixed 64-bit single-mode write-back unit.

## Interface
Parameters:
- DATA_W, 64, register and value width in bits
- NREGS, 15, number of architectural registers; valid indices are 0..NREGS-1, index 4'hF = RNONE
- RSP_IDX, 4, index of the stack pointer
- STACK_INIT, 0, reset value of register RSP_IDX
- BYPASS, 1, 1 = read ports return the value being written this cycle; 0 = read ports return stored contents only
- CNT_W, 32, width of the retired counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid  in  1  the current instruction commits this cycle
- icode  in  4  Y86 instruction code
- rA, rB  in  4  register specifiers
- cnd  in  1  condition result (cmovXX)
- valE, valM  in  DATA_W  ALU result / memory read value
- srcA, srcB  in  4  read port indices
- rdataA, rdataB  out  DATA_W  read data
- dstE, dstM  out  4  decoded destinations (combinational; 4'hF = none)
- halted  out  1  a halt instruction has retired
- retired  out  CNT_W  count of committed instructions

## Operation
- Destination decode (combinational, independent of valid):
  - dstE: rB for 2 (rrmovq/cmovXX) when cnd=1, otherwise F; rB for 3 (irmovq) and 6 (OPq); RSP_IDX for 8, 9, A, B (call, ret, pushq, popq); F for all other codes.
  - dstM: rA for 5 (mrmovq) and B (popq); F for all other codes.
- Commit condition: commit = valid & ~halted.
  - When commit=1, write valE to reg[dstE] if dstE < NREGS.
  - When commit=1, write valM to reg[dstM] if dstM < NREGS.
  - A destination of F, or any index >= NREGS, is silently dropped.
- Collision: if dstE == dstM, the valM write wins. Example: popq %rsp leaves reg[RSP] = valM.
- Halt: commit with icode 0 sets halted=1. Every later commit is suppressed, covering register writes and the counter, until rst.
- Counter: retired increments by 1 on each commit, including the halt instruction itself. It wraps modulo 2^CNT_W.
- Reads (combinational):
  - A source of F or an index >= NREGS reads as 0.
  - With BYPASS=1, a read whose source matches a committing dstM returns valM. Otherwise, if it matches a committing dstE, it returns valE. Otherwise it returns the stored value. The M-over-E priority is the same as for writes.
  - With BYPASS=0, reads always return the stored value.

## Timing
- Reset values (on the edge where rst=1):
  - All registers are 0, except reg[RSP_IDX] = STACK_INIT.
  - halted=0 and retired=0.
  - rst has priority over a simultaneous commit; that commit is discarded.
- Write latency is 1 cycle. A value committed at edge N is visible from storage after edge N. With BYPASS=1 it is also visible in the cycle before edge N.
- dstE, dstM and rdataA/B are purely combinational: no cycle of latency and no handshake.
- halted asserts after the edge that commits icode 0. The halt instruction's own dstE and dstM are F, so it writes nothing.
- rst asserted mid-run clears halted and returns every register to its reset value on that edge.

## Test plan
- Reset: hold rst with STACK_INIT=64'h100 -> all rdata 0 except srcA=4 gives 64'h100; retired=0, halted=0.
- irmovq (icode 3, rB=6, valE=140) then OPq (icode 6, rB=2, valE=10) -> reg6=140, reg2=10, retired=2. With BYPASS=1, srcA=6 shows 140 in the commit cycle itself.
- cmovXX (icode 2, rB=3, valE=9): cnd=0 -> dstE=F and reg3 unchanged; cnd=1 -> reg3=9.
- popq %rsp (icode B, rA=4, valE=40, valM=5) -> dstE=dstM=4 and reg4=5. popq rA=2 with valE=12, valM=7 -> reg4=12, reg2=7.
- Halt: icode 0 commits -> halted=1, retired increments once. A following irmovq rB=1, valE=77 -> reg1 unchanged and retired unchanged. rst -> halted=0.
- Boundary: NREGS=15, irmovq with rB=F -> no write; rst and commit on the same edge -> reset values only. CNT_W=4 with 16 commits -> retired wraps to 0.
